// File: rtl/mem_access.sv
// MIPS memory stage: EX/MEM register, load/store unit on a req/ack bus,
// write-back formatting, forwarding taps and bus timeout.
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cregwa_i,
    input  logic [1:0]  cregwd_i,
    input  logic        regwe_i,
    input  logic [1:0]  memlen_i,
    input  logic        memwe_i,
    input  logic [31:0] rd2_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] aluout_i,
    input  logic [31:0] dm_rdata_i,
    input  logic        dm_ack_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_wdata_o,
    output logic        stall_o,
    output logic        regwe_o,
    output logic [4:0]  wa_o,
    output logic [31:0] wd_o,
    output logic [1:0]  cwd_mem,
    output logic        we_mem,
    output logic [4:0]  wa_mem,
    output logic [31:0] wd_mem,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;

    logic        r_cregwa;
    logic [1:0]  r_cregwd;
    logic        r_regwe;
    logic [1:0]  r_memlen;
    logic        r_memwe;
    logic [31:0] r_rd2;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [31:0] r_alu;

    logic        w_in_memop;
    logic        w_in_go;
    logic        w_store;
    logic        w_load;
    logic        w_memop;
    logic        w_mis;
    logic        w_req;
    logic        w_stall;
    logic        w_berr;
    logic        w_regwe;
    logic        w_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_ld;
    logic [31:0] w_wd;

    function automatic logic f_misalign(
        input logic [1:0] len,
        input logic [1:0] a
    );
        return ((len == 2'b00) && (a != 2'b00)) ||
               ((len == 2'b01) && a[0]);
    endfunction

    assign w_in_memop = memwe_i | (cregwd_i == 2'b01);
    assign w_in_go    = w_in_memop & ~f_misalign(memlen_i, aluout_i[1:0]);

    // A store wins when the op is also tagged as a load.
    assign w_store = r_memwe;
    assign w_load  = (r_cregwd == 2'b01) & ~r_memwe;
    assign w_memop = w_store | w_load;
    assign w_mis   = w_memop & f_misalign(r_memlen, r_alu[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cregwa <= 1'b0;
            r_cregwd <= 2'b00;
            r_regwe  <= 1'b0;
            r_memlen <= 2'b00;
            r_memwe  <= 1'b0;
            r_rd2    <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_alu    <= '0;
        end else if (!w_stall) begin
            r_cregwa <= cregwa_i;
            r_cregwd <= cregwd_i;
            r_regwe  <= regwe_i;
            r_memlen <= memlen_i;
            r_memwe  <= memwe_i;
            r_rd2    <= rd2_i;
            r_rt     <= rt_i;
            r_rd     <= rd_i;
            r_alu    <= aluout_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_berr      = 1'b0;
        w_regwe     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_regwe = r_regwe & ~w_memop;
                if (w_in_go) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = '0;
                end
            end
            S_ACCESS: begin
                w_req = 1'b1;
                if (dm_ack_i) begin
                    w_regwe = r_regwe;
                    w_done  = 1'b1;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_berr = 1'b1;
                    w_done = 1'b1;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + 8'd1;
                end
                // The freed register takes the next op on this same edge.
                if (w_done) begin
                    w_state_nxt = w_in_go ? S_ACCESS : S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_rd2;
        case (r_memlen)
            2'b00: begin
                w_be    = 4'b1111;
                w_wdata = r_rd2;
            end
            2'b01: begin
                w_be    = r_alu[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_rd2[15:0]}};
            end
            default: begin
                w_be    = 4'b0001 << r_alu[1:0];
                w_wdata = {4{r_rd2[7:0]}};
            end
        endcase
    end

    assign w_half = r_alu[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];

    always_comb begin
        w_byte = dm_rdata_i[7:0];
        case (r_alu[1:0])
            2'b00:   w_byte = dm_rdata_i[7:0];
            2'b01:   w_byte = dm_rdata_i[15:8];
            2'b10:   w_byte = dm_rdata_i[23:16];
            default: w_byte = dm_rdata_i[31:24];
        endcase
    end

    always_comb begin
        w_ld = dm_rdata_i;
        case (r_memlen)
            2'b00:   w_ld = dm_rdata_i;
            2'b01:   w_ld = {{16{w_half[15]}}, w_half};
            2'b10:   w_ld = {{24{w_byte[7]}}, w_byte};
            default: w_ld = {24'd0, w_byte};
        endcase
    end

    assign w_wd = ((r_state == S_ACCESS) && w_load) ? w_ld : r_alu;

    assign dm_req_o   = w_req;
    assign dm_we_o    = w_req & w_store;
    assign dm_addr_o  = w_req ? {r_alu[31:2], 2'b00} : '0;
    assign dm_be_o    = w_req ? w_be : '0;
    assign dm_wdata_o = w_req ? w_wdata : '0;

    assign stall_o    = w_stall;
    assign regwe_o    = w_regwe;
    assign wa_o       = r_cregwa ? r_rd : r_rt;
    assign wd_o       = w_wd;
    assign misalign_o = w_mis;
    assign bus_err_o  = w_berr;

    assign cwd_mem = r_cregwd;
    assign we_mem  = w_regwe;
    assign wa_mem  = wa_o;
    assign wd_mem  = (r_cregwd == 2'b01) ? '0 : w_wd;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: random ops, bus responder, reference
// model computed from the access rules, and a retire monitor.
module tb_mem_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cregwa_i;
    logic [1:0]  cregwd_i;
    logic        regwe_i;
    logic [1:0]  memlen_i;
    logic        memwe_i;
    logic [31:0] rd2_i;
    logic [4:0]  rt_i;
    logic [4:0]  rd_i;
    logic [31:0] aluout_i;
    logic [31:0] dm_rdata_i;
    logic        dm_ack_i;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [31:0] dm_addr_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_wdata_o;
    logic        stall_o;
    logic        regwe_o;
    logic [4:0]  wa_o;
    logic [31:0] wd_o;
    logic [1:0]  cwd_mem;
    logic        we_mem;
    logic [4:0]  wa_mem;
    logic [31:0] wd_mem;
    logic        misalign_o;
    logic        bus_err_o;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cregwa_i(cregwa_i), .cregwd_i(cregwd_i),
        .regwe_i(regwe_i), .memlen_i(memlen_i),
        .memwe_i(memwe_i), .rd2_i(rd2_i),
        .rt_i(rt_i), .rd_i(rd_i), .aluout_i(aluout_i),
        .dm_rdata_i(dm_rdata_i), .dm_ack_i(dm_ack_i),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
        .dm_addr_o(dm_addr_o), .dm_be_o(dm_be_o),
        .dm_wdata_o(dm_wdata_o), .stall_o(stall_o),
        .regwe_o(regwe_o), .wa_o(wa_o), .wd_o(wd_o),
        .cwd_mem(cwd_mem), .we_mem(we_mem),
        .wa_mem(wa_mem), .wd_mem(wd_mem),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cregwa;
        logic [1:0]  cregwd;
        logic        regwe;
        logic [1:0]  memlen;
        logic        memwe;
        logic [31:0] rd2;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] alu;
        int          delay;
        logic [31:0] rdata;
    } op_t;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        regwe;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mis;
        logic        berr;
        int          stalls;
        logic [1:0]  cwd;
    } exp_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } job_t;

    exp_t expq[$];
    job_t jobq[$];
    op_t  ops[$];
    int   errs = 0;
    int   n_chk = 0;
    bit   run = 1'b1;

    task automatic chk(input string name,
                       input logic [159:0] act,
                       input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        errs++;
        $display("FAIL %s: got event want none", name);
    endtask

    function automatic exp_t model(input op_t o);
        exp_t e;
        bit ld, st, mem, mis, tmo;
        int a;
        logic [31:0] v;
        ld  = (o.cregwd == 2'd1) && !o.memwe;
        st  = o.memwe;
        mem = ld || st;
        a   = int'(o.alu[1:0]);
        mis = mem && ((o.memlen == 2'd0 && a != 0) ||
                      (o.memlen == 2'd1 && (a % 2) == 1));
        tmo = mem && !mis && o.delay >= TO;
        e.req   = mem && !mis;
        e.we    = st;
        e.addr  = o.alu & 32'hFFFF_FFFC;
        if (o.memlen == 2'd0) begin
            e.be    = 4'hF;
            e.wdata = o.rd2;
        end else if (o.memlen == 2'd1) begin
            e.be    = 4'(3 << (a & 2));
            e.wdata = (o.rd2 & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e.be    = 4'(1 << a);
            e.wdata = (o.rd2 & 32'hFF) * 32'h0101_0101;
        end
        e.mis    = mis;
        e.berr   = tmo;
        e.stalls = !e.req ? 0 : (tmo ? TO - 1 : o.delay);
        e.regwe  = o.regwe && !mis && !tmo;
        e.wa     = o.cregwa ? o.rd : o.rt;
        e.cwd    = o.cregwd;
        e.wd     = o.alu;
        if (ld && e.req) begin
            if (o.memlen == 2'd0) begin
                v = o.rdata;
            end else if (o.memlen == 2'd1) begin
                v = (o.rdata >> (8 * (a & 2))) & 32'hFFFF;
                if (v >= 32'h8000) v = v - 32'h1_0000;
            end else begin
                v = (o.rdata >> (8 * a)) & 32'hFF;
                if (o.memlen == 2'd2 && v >= 32'h80)
                    v = v - 32'h100;
            end
            e.wd = v;
        end
        return e;
    endfunction

    task automatic drive(input op_t o);
        cregwa_i = o.cregwa;
        cregwd_i = o.cregwd;
        regwe_i  = o.regwe;
        memlen_i = o.memlen;
        memwe_i  = o.memwe;
        rd2_i    = o.rd2;
        rt_i     = o.rt;
        rd_i     = o.rd;
        aluout_i = o.alu;
    endtask

    function automatic op_t mk(input logic [1:0] cwd,
                               input logic we,
                               input logic [1:0] len,
                               input logic [31:0] alu,
                               input logic [31:0] rd2,
                               input int dly,
                               input logic [31:0] rdata);
        op_t o;
        o = '{default: 0};
        o.cregwa = 1'b1;
        o.cregwd = cwd;
        o.regwe  = (cwd == 2'd1);
        o.memwe  = we;
        o.memlen = len;
        o.alu    = alu;
        o.rd2    = rd2;
        o.rt     = 5'd9;
        o.rd     = 5'd7;
        o.delay  = dly;
        o.rdata  = rdata;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        int k;
        o = '{default: 0};
        k = $urandom_range(0, 9);
        o.cregwa = 1'($urandom);
        o.regwe  = 1'($urandom);
        o.memlen = 2'($urandom);
        o.rd2    = $urandom;
        o.rt     = 5'($urandom);
        o.rd     = 5'($urandom);
        o.alu    = $urandom;
        o.rdata  = $urandom;
        o.delay  = $urandom_range(0, 5);
        o.cregwd = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2 + 2'($urandom_range(0, 1));
        if (k >= 4 && k <= 6) o.cregwd = 2'd1;
        if (k >= 7) o.memwe = 1'b1;
        if (k == 9) o.cregwd = 2'd1;
        if (k >= 4 && $urandom_range(0, 3) != 0) begin
            if (o.memlen == 2'd0) o.alu[1:0] = 2'b00;
            if (o.memlen == 2'd1) o.alu[0] = 1'b0;
        end
        return o;
    endfunction

    initial begin : responder
        bit   active;
        int   cnt;
        job_t j;
        active = 1'b0;
        cnt = 0;
        j = '{default: 0};
        dm_ack_i = 1'b0;
        dm_rdata_i = '0;
        while (run) begin
            @(negedge clk);
            dm_ack_i = 1'b0;
            if (rst) continue;
            if (dm_req_o && !active) begin
                if (jobq.size() == 0) begin
                    flag("unexpected_req");
                end else begin
                    j = jobq.pop_front();
                    active = 1'b1;
                    cnt = 0;
                end
            end
            if (active) begin
                dm_rdata_i = j.rdata;
                dm_ack_i = (cnt == j.delay);
            end else begin
                dm_rdata_i = $urandom;
                dm_ack_i = ($urandom_range(0, 3) == 0);
            end
            #1;
            if (active) begin
                if (dm_ack_i || bus_err_o) active = 1'b0;
                else cnt++;
            end
        end
        dm_ack_i = 1'b0;
    end

    initial begin : monitor
        int   st;
        exp_t e;
        st = 0;
        while (run) begin
            @(negedge clk);
            #2;
            if (rst) continue;
            if (!dm_req_o)
                chk("dm_idle_zero",
                    {dm_we_o, dm_be_o, dm_addr_o, dm_wdata_o}, 0);
            if (expq.size() == 0) begin
                if (!stall_o) flag("retire_empty");
                continue;
            end
            e = expq[0];
            chk("dm_req", dm_req_o, e.req);
            if (e.req) begin
                chk("dm_we", dm_we_o, e.we);
                chk("dm_addr", dm_addr_o, e.addr);
                chk("dm_be", dm_be_o, e.be);
                chk("dm_wdata", dm_wdata_o, e.wdata);
            end
            if (stall_o) begin
                st++;
                if (st > TO + 2) begin
                    flag("stall_stuck");
                    st = 0;
                end
            end else begin
                void'(expq.pop_front());
                chk("regwe", regwe_o, e.regwe);
                chk("wa", wa_o, e.wa);
                chk("misalign", misalign_o, e.mis);
                chk("bus_err", bus_err_o, e.berr);
                chk("stall_cycles", st, e.stalls);
                chk("we_mem", we_mem, e.regwe);
                chk("wa_mem", wa_mem, e.wa);
                chk("cwd_mem", cwd_mem, e.cwd);
                if (e.regwe) chk("wd", wd_o, e.wd);
                if (e.cwd == 2'd1) chk("wd_mem_zero", wd_mem, 0);
                else if (e.regwe) chk("wd_mem", wd_mem, e.wd);
                st = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        flag("watchdog");
        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

    initial begin : driver
        op_t  z;
        op_t  o;
        exp_t e;
        z = '{default: 0};
        rst = 1'b1;
        drive(z);
        ops.push_back(z);
        ops[0].alu = 32'h1234;
        ops[0].regwe = 1'b1;
        ops[0].cregwa = 1'b1;
        ops[0].rd = 5'd5;
        ops.push_back(mk(2'd0, 1'b1, 2'd2, 32'h1003, 32'hAABBCCDD, 3, 0));
        ops.push_back(mk(2'd1, 1'b0, 2'd1, 32'h2002, 0, 0, 32'h8001_0000));
        ops.push_back(mk(2'd1, 1'b0, 2'd3, 32'h2003, 0, 0, 32'h8001_0000));
        ops.push_back(mk(2'd1, 1'b0, 2'd0, 32'h3001, 0, 0, 0));
        ops.push_back(mk(2'd1, 1'b0, 2'd0, 32'h4000, 0, 10, 32'h55));
        ops.push_back(mk(2'd1, 1'b0, 2'd0, 32'h5000, 0, 0, 32'hCAFE_0001));
        ops.push_back(mk(2'd1, 1'b0, 2'd2, 32'h5005, 0, 0, 32'h0000_F000));
        repeat (200) ops.push_back(rnd_op());
        repeat (8) ops.push_back(z);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs",
            {dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
             stall_o, regwe_o, wa_o, wd_o, cwd_mem, we_mem,
             wa_mem, wd_mem, misalign_o, bus_err_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        expq.push_back(model(z));

        foreach (ops[i]) begin
            int tries;
            bit done;
            tries = 0;
            done = 1'b0;
            o = ops[i];
            while (!done) begin
                #3;
                drive(o);
                if (!stall_o) begin
                    e = model(o);
                    expq.push_back(e);
                    if (e.req) jobq.push_back('{o.delay, o.rdata});
                    done = 1'b1;
                end else if (++tries > 20) begin
                    flag("capture_timeout");
                    done = 1'b1;
                end
                @(negedge clk);
            end
        end
        run = 1'b0;
        repeat (3) @(negedge clk);

        #3;
        drive(mk(2'd1, 1'b0, 2'd0, 32'h6000, 0, 0, 0));
        chk("pre_load_idle", stall_o, 0);
        @(negedge clk);
        #1;
        chk("rst_mid_req", dm_req_o, 1);
        chk("rst_mid_stall", stall_o, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs",
            {dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
             stall_o, regwe_o, wa_o, wd_o, cwd_mem, we_mem,
             wa_mem, wd_mem, misalign_o, bus_err_o}, 0);
        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

endmodule
